// File: rtl/lfsr_rr_sched_pkg.sv
// Shared definitions for the LFSR round-robin scheduler: LFSR geometry,
// FSM encoding and the all-zero lockup substitute.
package lfsr_rr_sched_pkg;

  localparam int LFSR_W = 4;
  localparam int TAP_A  = 3;
  localparam int TAP_B  = 0;

  localparam logic [LFSR_W-1:0] LOCKUP_SUB = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_SEED  = 2'd2
  } state_e;

  // x^4 + x^3 + 1 Fibonacci step, period 15 for any non-zero state.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], q[TAP_A] ^ q[TAP_B]};
  endfunction

endpackage

// File: rtl/lfsr_rr_sched_core.sv
// LFSR register with load (zero-seed guarded) and advance enable.
module lfsr_core
  import lfsr_rr_sched_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 4'b0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  input  logic              ld,
  input  logic [LFSR_W-1:0] ld_val,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_q;
  logic [LFSR_W-1:0] q_d;

  // Load wins over advance; an all-zero seed would lock the LFSR, so substitute.
  always_comb begin
    q_d = q_q;
    if (ld) begin
      if (ld_val == {LFSR_W{1'b0}}) begin
        q_d = LOCKUP_SUB;
      end else begin
        q_d = ld_val;
      end
    end else if (adv) begin
      q_d = lfsr_next(q_q);
    end else begin
      q_d = q_q;
    end
  end

  // LFSR state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/lfsr_rr_sched.sv
// Round-robin scheduler handing out one LFSR word per grant; owns the
// arbiter, rotating pointer and IDLE/GRANT/SEED control FSM.
module lfsr_rr_sched
  import lfsr_rr_sched_pkg::*;
#(
  parameter int                N_REQ = 4,
  parameter logic [LFSR_W-1:0] SEED  = 4'b0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic              seed_ld,
  input  logic [LFSR_W-1:0] seed_in,
  output logic [N_REQ-1:0]  gnt,
  output logic [LFSR_W-1:0] rnd_out,
  output logic              rnd_valid,
  output logic              busy,
  output logic              wrap
);

  localparam int PTR_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [LFSR_W-1:0]   rnd_q, rnd_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                wrap_q, wrap_d;

  logic [LFSR_W-1:0]   lfsr_s;
  logic                adv_s;
  logic                ld_s;
  logic                found_s;
  logic [PTR_W-1:0]    win_s;
  logic [PTR_W-1:0]    ptr_nx_s;

  lfsr_core #(
    .SEED (SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .adv    (adv_s),
    .ld     (ld_s),
    .ld_val (seed_in),
    .q      (lfsr_s)
  );

  // First active requester at or above ptr, wrapping modulo N_REQ.
  always_comb begin
    found_s = 1'b0;
    win_s   = {PTR_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (!found_s && req[(int'(ptr_q) + i) % N_REQ]) begin
        found_s = 1'b1;
        win_s   = PTR_W'((int'(ptr_q) + i) % N_REQ);
      end
    end
    if (win_s == PTR_W'(N_REQ - 1)) begin
      ptr_nx_s = {PTR_W{1'b0}};
    end else begin
      ptr_nx_s = win_s + PTR_W'(1);
    end
  end

  // Control FSM: seed_ld outranks requests; SEED always returns to IDLE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = {N_REQ{1'b0}};
    rnd_d   = rnd_q;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    wrap_d  = 1'b0;
    adv_s   = 1'b0;
    ld_s    = 1'b0;
    case (state_q)
      ST_IDLE, ST_GRANT: begin
        if (seed_ld) begin
          state_d = ST_SEED;
          busy_d  = 1'b1;
        end else if (found_s) begin
          state_d = ST_GRANT;
          gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << win_s;
          rnd_d   = lfsr_s;
          valid_d = 1'b1;
          adv_s   = 1'b1;
          ptr_d   = ptr_nx_s;
          wrap_d  = (lfsr_next(lfsr_s) == SEED);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEED: begin
        ld_s    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= {PTR_W{1'b0}};
      gnt_q   <= {N_REQ{1'b0}};
      rnd_q   <= {LFSR_W{1'b0}};
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      rnd_q   <= rnd_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
    end
  end

  assign gnt       = gnt_q;
  assign rnd_out   = rnd_q;
  assign rnd_valid = valid_q;
  assign busy      = busy_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_lfsr_rr_sched.sv
// Self-checking bench for lfsr_rr_sched: directed scenarios plus random
// traffic compared against a table-driven reference model.
module tb_lfsr_rr_sched;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] req = '0;
  logic         seed_ld = 1'b0;
  logic [3:0]   seed_in = 4'b0000;
  logic [N-1:0] gnt;
  logic [3:0]   rnd_out;
  logic         rnd_valid;
  logic         busy;
  logic         wrap;

  int checks = 0;
  int errors = 0;

  lfsr_rr_sched #(.N_REQ(N), .SEED(4'b0001)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .seed_ld   (seed_ld),
    .seed_in   (seed_in),
    .gnt       (gnt),
    .rnd_out   (rnd_out),
    .rnd_valid (rnd_valid),
    .busy      (busy),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  // Reference: the documented 15-word sequence, indexed by position.
  logic [3:0] seq [0:14] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                             4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};
  int           m_pos;
  int           m_ptr;
  bit           m_inseed;
  logic [N-1:0] m_gnt;
  logic [3:0]   m_rnd;
  logic         m_valid, m_busy, m_wrap;

  function automatic void model_reset();
    m_pos = 0; m_ptr = 0; m_inseed = 0;
    m_gnt = '0; m_rnd = 4'h0; m_valid = 0; m_busy = 0; m_wrap = 0;
  endfunction

  function automatic void model_step(input logic [N-1:0] r, input logic sl, input logic [3:0] si);
    logic [3:0] v;
    int w;
    m_gnt = '0; m_valid = 0; m_busy = 0; m_wrap = 0;
    if (m_inseed) begin
      v = (si == 4'h0) ? 4'h1 : si;
      for (int k = 0; k < 15; k++) if (seq[k] == v) m_pos = k;
      m_inseed = 0;
    end else if (sl) begin
      m_inseed = 1;
      m_busy = 1;
    end else if (r != '0) begin
      w = -1;
      for (int k = 0; k < N; k++) if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      m_gnt   = N'(1) << w;
      m_rnd   = seq[m_pos];
      m_valid = 1;
      m_pos   = (m_pos + 1) % 15;
      m_wrap  = (m_pos == 0);
      m_ptr   = (w + 1) % N;
    end
  endfunction

  function automatic logic [N+6:0] obs();
    return {gnt, rnd_out, rnd_valid, busy, wrap};
  endfunction

  function automatic logic [N+6:0] expv();
    return {m_gnt, m_rnd, m_valid, m_busy, m_wrap};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(req, seed_ld, seed_in);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b0; req = '0; seed_ld = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs() !== '0) begin
      errors++;
      $display("FAIL reset_hold: got gnt=%b rnd=%h valid=%b busy=%b wrap=%b, want all zero",
               gnt, rnd_out, rnd_valid, busy, wrap);
    end
    rst = 1'b1;
    model_reset();
    tick();
    checks++;
    if (gnt !== 4'b0001 || rnd_out !== 4'b0001 || rnd_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant: got gnt=%b rnd=%h valid=%b, want 0001 1 1", gnt, rnd_out, rnd_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] er [4] = '{4'h1, 4'h3, 4'h7, 4'hF};
    apply_reset();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (gnt !== eg[i] || rnd_out !== er[i] || obs() !== expv()) begin
        errors++;
        $display("FAIL round_robin[%0d]: got gnt=%b rnd=%h, want gnt=%b rnd=%h", i, gnt, rnd_out, eg[i], er[i]);
      end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    req = 4'b0010;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (obs() !== expv() || gnt !== 4'b0010 || rnd_out !== seq[i % 15] ||
          wrap !== (i == 14)) begin
        errors++;
        $display("FAIL wrap[%0d]: got gnt=%b rnd=%h wrap=%b, want gnt=0010 rnd=%h wrap=%b",
                 i, gnt, rnd_out, wrap, seq[i % 15], (i == 14));
      end
    end
  endtask

  task automatic test_seed_priority();
    apply_reset();
    seed_ld = 1'b1; seed_in = 4'b1010; req = 4'b0100;
    tick();
    seed_ld = 1'b0;
    checks++;
    if (busy !== 1'b1 || gnt !== 4'b0000 || rnd_valid !== 1'b0) begin
      errors++;
      $display("FAIL seed_busy: got busy=%b gnt=%b, want busy=1 gnt=0000", busy, gnt);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || gnt !== 4'b0000) begin
      errors++;
      $display("FAIL seed_gap: got busy=%b gnt=%b, want busy=0 gnt=0000", busy, gnt);
    end
    tick();
    checks++;
    if (gnt !== 4'b0100 || rnd_out !== 4'b1010 || obs() !== expv()) begin
      errors++;
      $display("FAIL seed_grant: got gnt=%b rnd=%h, want gnt=0100 rnd=a", gnt, rnd_out);
    end
  endtask

  task automatic test_lockup();
    apply_reset();
    req = 4'b0001; tick(); tick();
    seed_ld = 1'b1; seed_in = 4'b0000;
    tick();
    seed_ld = 1'b0;
    tick(); tick();
    checks++;
    if (rnd_out !== 4'b0001 || gnt !== 4'b0001 || wrap !== 1'b0 || obs() !== expv()) begin
      errors++;
      $display("FAIL lockup_guard: got gnt=%b rnd=%h wrap=%b, want gnt=0001 rnd=1 wrap=0", gnt, rnd_out, wrap);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req = 4'b1111;
    repeat (3) tick();
    #3 rst = 1'b0;
    #1;
    checks++;
    if (obs() !== '0) begin
      errors++;
      $display("FAIL async_clear: got gnt=%b rnd=%h valid=%b, want all zero", gnt, rnd_out, rnd_valid);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    tick();
    checks++;
    if (gnt !== 4'b0001 || rnd_out !== 4'b0001 || obs() !== expv()) begin
      errors++;
      $display("FAIL async_first_grant: got gnt=%b rnd=%h, want gnt=0001 rnd=1", gnt, rnd_out);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      req = N'($urandom);
      if (!m_inseed && $urandom_range(0, 15) == 0) begin
        seed_ld = 1'b1;
        seed_in = 4'($urandom);
      end else begin
        seed_ld = 1'b0;
      end
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL random[%0d]: got %b, want %b (gnt,rnd,valid,busy,wrap)", i, obs(), expv());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_wrap();
    test_seed_priority();
    test_lockup();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_rr_sched.md
# lfsr_rr_sched

Round-robin scheduler that shares one 4-bit Fibonacci LFSR among up to N_REQ requesters. Each grant delivers the current LFSR word to exactly one requester and advances the LFSR by one step, so no two consumers ever receive the same sample within a period. It also handles reseeding and all-zero lockup protection, and flags each completed 15-state period. It sits between the LFSR datapath, which it instantiates, and the blocks that consume pseudo-random words.

## Interface
- N_REQ, 4: number of requesters; legal range 2..8.
- SEED, 4'b0001: LFSR state after reset; must be non-zero.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  N_REQ  level request per requester.
- seed_ld  in  1  single-cycle request to load seed_in into the LFSR.
- seed_in  in  4  new seed value.
- gnt  out  N_REQ  registered grant, one-hot or zero.
- rnd_out  out  4  LFSR word delivered with gnt; holds its value when not granting.
- rnd_valid  out  1  high exactly when gnt is non-zero.
- busy  out  1  high while the FSM is in SEED.
- wrap  out  1  one-cycle pulse when an advance returns the LFSR to SEED.

## Operation
- LFSR next-state function: next = {q[2:0], q[3]^q[0]}, which is x^4+x^3+1, period 15.
- Sequence from 0001: 0001, 0011, 0111, 1111, 1110, 1101, 1010, 0101, 1011, 0110, 1100, 1001, 0010, 0100, 1000, then back to 0001.
- FSM states: IDLE, GRANT, SEED. Reset state is IDLE.
- IDLE or GRANT, seed_ld=1 -> SEED.
  - seed_ld has priority over any pending req in that cycle.
  - No grant is issued in that cycle.
- IDLE or GRANT, seed_ld=0, req non-zero -> GRANT.
  - Winner = first set bit of req, searching upward from ptr and wrapping modulo N_REQ.
  - gnt is set to onehot(winner), rnd_out to the current LFSR value, rnd_valid to 1.
  - The LFSR advances one step; ptr becomes (winner+1) mod N_REQ.
- IDLE or GRANT, seed_ld=0, req zero -> IDLE; gnt=0, rnd_valid=0.
- SEED:
  - The LFSR loads seed_in. If seed_in is 0000, it loads 0001 instead (lockup guard).
  - gnt=0, rnd_valid=0, busy=1. ptr is unchanged.
  - Next state is always IDLE. Requests wait at least one further cycle.
- wrap asserts on the same edge as a grant whose LFSR advance produces SEED. A seed load never asserts wrap.
- Requesters hold req until they see their gnt bit.
  - A requester that keeps req high after its grant re-enters arbitration and is served again only after every other active requester.
  - Dropping req before the grant withdraws the request with no side effect.
- ptr reset value is 0.

## Timing
- Latency: req sampled at edge k produces gnt, rnd_out and rnd_valid valid after edge k (one cycle).
- Throughput: one grant per cycle while requests are pending; GRANT may chain directly into GRANT.
- Reset (rst=0, asynchronous):
  - state=IDLE, LFSR=SEED, ptr=0.
  - gnt=0, rnd_valid=0, rnd_out=0000, busy=0, wrap=0.
- Reset asserted mid-grant: outputs clear immediately. The interrupted grant is lost and the LFSR returns to SEED.
- seed_ld together with req: the seed is loaded, the grant is deferred by 2 cycles, and the next grant delivers the new seed.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package holds:
  - the LFSR width (4) and tap positions;
  - the FSM state encoding (IDLE=2'd0, GRANT=2'd1, SEED=2'd2);
  - the lockup-substitute constant 4'b0001.
- One sub-module, lfsr_core (clk, rst, adv, ld, ld_val, q), containing the LFSR register and its next-state logic with enable and load.
- Arbiter, pointer and FSM live in lfsr_rr_sched.

## Test plan
- Reset: hold rst=0 with req=4'b1111 -> gnt=0, rnd_valid=0, rnd_out=0000. After release, the first grant is gnt=0001 with rnd_out=0001.
- Round robin: req=4'b1111 held for 4 cycles -> gnt=0001, 0010, 0100, 1000 with rnd_out=0001, 0011, 0111, 1111.
- Wrap: a single requester held for 15 grants -> the full 15-word sequence; wrap pulses with the 15th grant (rnd_out=1000). The 16th grant delivers 0001.
- Seed priority: seed_ld=1 with seed_in=1010 and req=4'b0100 in the same cycle -> busy=1 for one cycle with no grant. Two cycles later gnt=0100 with rnd_out=1010.
- Lockup guard: seed_ld with seed_in=0000 -> the next grant delivers rnd_out=0001.
- Async reset mid-stream: assert rst between clock edges during chained grants -> outputs clear immediately, and the first post-reset grant delivers 0001 to requester 0.
